// File: rtl/cardio_axil_regs.sv
// AXI4-Lite slave register file for the cardio analysis datapath.
// Four RW control words (0..3), one RO result word (4), words 5..7 unmapped.
// One outstanding write and one outstanding read; the channels are independent.
module cardio_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     RESULT_IN,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG0_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG1_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG2_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG3_OUT
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         NSTRB       = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Protection bits and byte offsets carry no meaning for a word-decoded register file.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_t                          r_wstate;
    logic                              r_awready;
    logic                              r_wready;
    logic                              r_aw_have;
    logic                              r_w_have;
    logic [2:0]                        r_aw_word;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [NSTRB-1:0]                  r_wstrb;
    logic                              r_bvalid;
    logic [1:0]                        r_bresp;
    logic                              w_commit;

    // The commit happens on the edge after both halves of the write are held.
    assign w_commit = (r_wstate == W_IDLE) && r_aw_have && r_w_have;

    // Write FSM: independent AW/W capture, commit, then hold B until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_aw_word <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    // READY rises on the first edge out of reset and stays up until a capture.
                    if (S_AXI_AWVALID && r_awready) begin
                        r_aw_word <= S_AXI_AWADDR[4:2];
                        r_aw_have <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_have) begin
                        r_awready <= 1'b1;
                    end
                    if (S_AXI_WVALID && r_wready) begin
                        r_wdata  <= S_AXI_WDATA;
                        r_wstrb  <= S_AXI_WSTRB;
                        r_w_have <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_have) begin
                        r_wready <= 1'b1;
                    end
                    if (w_commit) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= (r_aw_word >= 3'd5) ? RESP_SLVERR : RESP_OKAY;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_aw_have <= 1'b0;
                        r_w_have  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers, one instance per RW word
    // ------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] w_regs [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [C_S_AXI_DATA_WIDTH-1:0] r_reg;

            // Byte-lane merge of the held write data into this word on commit.
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_reg <= '0;
                end else if (w_commit && (r_aw_word == 3'(gi))) begin
                    for (int b = 0; b < NSTRB; b++) begin
                        if (r_wstrb[b]) begin
                            r_reg[8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end

            assign w_regs[gi] = r_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                          r_rstate;
    logic                              r_arready;
    logic                              r_ar_have;
    logic [2:0]                        r_ar_word;
    logic                              r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                        r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_rd_value;

    // Read decode of the held word index; unmapped words read as zero.
    always_comb begin
        w_rd_value = '0;
        case (r_ar_word)
            3'd0:    w_rd_value = w_regs[0];
            3'd1:    w_rd_value = w_regs[1];
            3'd2:    w_rd_value = w_regs[2];
            3'd3:    w_rd_value = w_regs[3];
            3'd4:    w_rd_value = RESULT_IN;
            default: w_rd_value = '0;
        endcase
    end

    // Read FSM: capture AR, then present R one edge later and hold it until accepted.
    // The capture uses the register values before any commit on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_ar_have <= 1'b0;
            r_ar_word <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_ar_have) begin
                        r_rdata  <= w_rd_value;
                        r_rresp  <= (r_ar_word >= 3'd5) ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end else if (S_AXI_ARVALID && r_arready) begin
                        r_ar_word <= S_AXI_ARADDR[4:2];
                        r_ar_have <= 1'b1;
                        r_arready <= 1'b0;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_ar_have <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign REG0_OUT      = w_regs[0];
    assign REG1_OUT      = w_regs[1];
    assign REG2_OUT      = w_regs[2];
    assign REG3_OUT      = w_regs[3];

endmodule

// File: doc/cardio_axil_regs.md
Name: cardio_axil_regs

Overview:
- AXI4-Lite slave register file: the responder end of the AXI4-Lite master traffic that the CardioAnalyseIP bench drives.
- Holds four read/write 32-bit control registers and one read-only result register fed by the cardio analysis core.
- Sits between the AXI interconnect (S00_AXI) and the analysis datapath.
- Supports one outstanding write and one outstanding read; address decode is on word boundaries.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; ADDR[4:2] is the word index, ADDR[1:0] is ignored.

Ports:
ACLK  in  1  the single clock; all logic is rising-edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte lane enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
RESULT_IN  in  32  analysis result; sampled when a read of word 4 is accepted.
REG0_OUT..REG3_OUT  out  32 each  current register contents, driven straight to the datapath.

Behaviour:
- Reset (async assert, sync release):
  - REG0..3 = 0; all *READY, BVALID, RVALID = 0; BRESP/RRESP = 00; RDATA = 0.
  - On the first rising edge after ARESET falls, AWREADY, WREADY and ARREADY go to 1.
- Address map (word index):
  - 0..3: RW registers.
  - 4: read-only RESULT_IN.
  - 5..7: unmapped.
- Write channel FSM with states W_IDLE, W_RESP:
  - W_IDLE: AW and W handshake independently, in either order or in the same cycle.
  - On each handshake, latch AWADDR or WDATA/WSTRB and drop the matching READY next cycle until the response completes.
  - Once both are latched (handshakes at edge N, or the later of the two), at edge N+1:
    - the target register is updated per WSTRB byte lane;
    - BVALID = 1; state -> W_RESP.
  - Writes to word 4 or 5..7 leave every register unchanged. Word 4 returns BRESP OKAY; 5..7 return BRESP SLVERR.
  - WSTRB = 0000 is legal: no change, OKAY.
  - W_RESP: hold BVALID and BRESP stable until BREADY. At the BVALID&BREADY edge, BVALID = 0, AWREADY = WREADY = 1, state -> W_IDLE.
  - Back-to-back: a new AW/W can handshake at the earliest one cycle after the B handshake.
- Read channel FSM with states R_IDLE, R_DATA:
  - ARVALID&ARREADY at edge N -> at edge N+1: RDATA = decoded value, RVALID = 1, ARREADY = 0.
  - Unmapped words 5..7: RDATA = 0, RRESP = SLVERR.
  - Hold RDATA/RRESP stable while RVALID & !RREADY.
  - At the RVALID&RREADY edge: RVALID = 0, ARREADY = 1.
- Simultaneous events:
  - Read and write channels are fully independent.
  - If a register commit and a read capture of the same word happen on the same edge, RDATA returns the pre-write value.
- REGn_OUT reflects the new value the cycle after commit.
- ARESET mid-transaction:
  - Outstanding responses are dropped; latched AW/W are discarded; registers clear immediately.
  - No BVALID/RVALID is issued for the dropped transactions.

Test Plan:
- Four sequential writes (AWADDR 0x0, 0x4, 0x8, 0xC; WDATA 1, 2, 3, 4; WSTRB F) then reads of the same addresses -> each BRESP = 00; reads return 1, 2, 3, 4 with RRESP = 00; REG0..3_OUT = 1..4.
- Byte strobe: write 0xAABBCCDD to 0x0 with WSTRB 1111, then 0x11223344 with WSTRB 0101 -> read 0x0 returns 0xAA22CC44.
- Channel ordering: W presented 3 cycles before AW, then AW-only-first case, then both in the same cycle -> every case commits exactly once; BVALID rises one cycle after the second handshake.
- Backpressure: BREADY and RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable; no second AW/AR accepted until released.
- Decode: RESULT_IN = 0x0000_0048, read 0x10 -> 0x48 OKAY; write 0x10 -> OKAY, no register change; read/write 0x14 -> SLVERR, RDATA 0.
- Reset mid-write: AW+W accepted, ARESET pulsed before BREADY -> BVALID = 0 and REG0..3 = 0 immediately; all READYs return to 1 one edge after release.
